// File: rtl/grid_pkg.sv
// Shared definitions for the grid cell painter: FSM state encoding, default
// grid geometry (origin, pitch, cell size) and the visible screen limits.
package grid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_NEXT = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam int unsigned DEF_COLS     = 3;
    localparam int unsigned DEF_ROWS     = 3;
    localparam int unsigned DEF_ORIGIN_X = 152;
    localparam int unsigned DEF_ORIGIN_Y = 226;
    localparam int unsigned DEF_PITCH_X  = 130;
    localparam int unsigned DEF_PITCH_Y  = 100;
    localparam int unsigned DEF_CELL_W   = 80;
    localparam int unsigned DEF_CELL_H   = 50;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    // Row/column counters cover grids up to 16x16.
    localparam int unsigned RC_W = 4;

endpackage

// File: rtl/rect_scanner.sv
// Row-major pixel scanner for one rectangle.
// Ports: clk, reset (async, active-high); start restarts at (0,0); step
// advances one pixel; width/height give the rectangle size. px_nxt_c/py_nxt_c
// are the counter values after this cycle's start/step, last_pixel_c flags
// that the current position is the bottom-right pixel.
module rect_scanner #(
    parameter int unsigned PX_W = 10,
    parameter int unsigned PY_W = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            step,
    input  logic [PX_W-1:0] width,
    input  logic [PY_W-1:0] height,
    output logic [PX_W-1:0] px_nxt_c,
    output logic [PY_W-1:0] py_nxt_c,
    output logic            last_pixel_c
);

    logic [PX_W-1:0] px;
    logic [PY_W-1:0] py;
    logic            px_last;
    logic            py_last;

    assign px_last      = (px == width - PX_W'(1));
    assign py_last      = (py == height - PY_W'(1));
    assign last_pixel_c = px_last & py_last;

    // Next position: restart, step with wrap onto the next line, or hold.
    always_comb begin
        px_nxt_c = px;
        py_nxt_c = py;
        if (start) begin
            px_nxt_c = '0;
            py_nxt_c = '0;
        end else if (step) begin
            if (px_last) begin
                px_nxt_c = '0;
                py_nxt_c = py + PY_W'(1);
            end else begin
                px_nxt_c = px + PX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            px <= '0;
            py <= '0;
        end else begin
            px <= px_nxt_c;
            py <= py_nxt_c;
        end
    end

endmodule

// File: rtl/grid_cell_painter.sv
// Paints one cell (or every cell) of a ROWS x COLS grid of rectangles, one
// pixel per clock, onto the VGA adapter's x/y/colour/plot interface.
// Ports: clk, reset (async, active-high); req/clear_all/cell_idx/colour_in
// request a paint while ready=1; x/y/colour/plot carry pixels; done pulses
// after the last pixel of a request, err pulses on an out-of-range index.
module grid_cell_painter
    import grid_pkg::*;
#(
    parameter int unsigned COLS     = DEF_COLS,
    parameter int unsigned ROWS     = DEF_ROWS,
    parameter int unsigned ORIGIN_X = DEF_ORIGIN_X,
    parameter int unsigned ORIGIN_Y = DEF_ORIGIN_Y,
    parameter int unsigned PITCH_X  = DEF_PITCH_X,
    parameter int unsigned PITCH_Y  = DEF_PITCH_Y,
    parameter int unsigned CELL_W   = DEF_CELL_W,
    parameter int unsigned CELL_H   = DEF_CELL_H,
    parameter int unsigned X_W      = 10,
    parameter int unsigned Y_W      = 9,
    parameter int unsigned COLOUR_W = 3,
    parameter int unsigned IDX_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic                clear_all,
    input  logic [IDX_W-1:0]    cell_idx,
    input  logic [COLOUR_W-1:0] colour_in,
    output logic                ready,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                done,
    output logic                err
);

    localparam int unsigned N_CELLS = ROWS * COLS;
    localparam int unsigned SX_W    = X_W + 2;
    localparam int unsigned SY_W    = Y_W + 2;

    // Integration checks: geometry must fit the grid limits and the screen.
    if (COLS < 1 || COLS > 16 || ROWS < 1 || ROWS > 16) begin : g_bad_grid
        $error("grid_cell_painter: ROWS/COLS must be 1..16");
    end
    if (ORIGIN_X + (COLS - 1) * PITCH_X + CELL_W > SCREEN_W ||
        ORIGIN_Y + (ROWS - 1) * PITCH_Y + CELL_H > SCREEN_H) begin : g_bad_fit
        $error("grid_cell_painter: grid does not fit on a 640x480 screen");
    end

    state_t          state, state_d;
    logic [RC_W-1:0] row, col, row_d, col_d;
    logic [RC_W-1:0] dec_row, dec_col;
    logic            clr_mode, clr_mode_d;
    logic            plot_d, done_d, err_d;
    logic            scan_start, scan_step, load_pix, load_colour;
    logic            in_range, last_cell;
    logic            last_pixel_c;
    logic [X_W-1:0]  px_nxt_c;
    logic [Y_W-1:0]  py_nxt_c;
    logic [SX_W-1:0] x_sum;
    logic [SY_W-1:0] y_sum;

    rect_scanner #(
        .PX_W (X_W),
        .PY_W (Y_W)
    ) u_scan (
        .clk          (clk),
        .reset        (reset),
        .start        (scan_start),
        .step         (scan_step),
        .width        (X_W'(CELL_W)),
        .height       (Y_W'(CELL_H)),
        .px_nxt_c     (px_nxt_c),
        .py_nxt_c     (py_nxt_c),
        .last_pixel_c (last_pixel_c)
    );

    assign in_range  = (32'(cell_idx) < N_CELLS);
    assign last_cell = (row == RC_W'(ROWS - 1)) && (col == RC_W'(COLS - 1));

    // Index -> row/col by comparing against constant row starts (no divider).
    always_comb begin
        dec_row = '0;
        for (int unsigned r = 1; r < ROWS; r++) begin
            if (32'(cell_idx) >= r * COLS) dec_row = RC_W'(r);
        end
        dec_col = RC_W'(32'(cell_idx) - 32'(dec_row) * COLS);
    end

    // Coordinates of the pixel shown next cycle, from next-cycle row/col/px/py.
    assign x_sum = SX_W'(ORIGIN_X) + SX_W'(col_d) * SX_W'(PITCH_X) + SX_W'(px_nxt_c);
    assign y_sum = SY_W'(ORIGIN_Y) + SY_W'(row_d) * SY_W'(PITCH_Y) + SY_W'(py_nxt_c);

    // Next-state and output decode.
    always_comb begin
        state_d     = state;
        row_d       = row;
        col_d       = col;
        clr_mode_d  = clr_mode;
        plot_d      = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        scan_start  = 1'b0;
        scan_step   = 1'b0;
        load_pix    = 1'b0;
        load_colour = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req && ready) begin
                    if (clear_all || in_range) begin
                        clr_mode_d  = clear_all;
                        row_d       = clear_all ? '0 : dec_row;
                        col_d       = clear_all ? '0 : dec_col;
                        load_colour = 1'b1;
                        scan_start  = 1'b1;
                        load_pix    = 1'b1;
                        plot_d      = 1'b1;
                        state_d     = ST_DRAW;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_DRAW: begin
                if (!last_pixel_c) begin
                    scan_step = 1'b1;
                    load_pix  = 1'b1;
                    plot_d    = 1'b1;
                end else if (clr_mode && !last_cell) begin
                    state_d = ST_NEXT;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_FIN;
                end
            end
            ST_NEXT: begin
                if (col == RC_W'(COLS - 1)) begin
                    col_d = '0;
                    row_d = row + RC_W'(1);
                end else begin
                    col_d = col + RC_W'(1);
                end
                scan_start = 1'b1;
                load_pix   = 1'b1;
                plot_d     = 1'b1;
                state_d    = ST_DRAW;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_d;
    end

    // Control/status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row      <= '0;
            col      <= '0;
            clr_mode <= 1'b0;
            ready    <= 1'b1;
            plot     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            row      <= row_d;
            col      <= col_d;
            clr_mode <= clr_mode_d;
            ready    <= (state_d == ST_IDLE);
            plot     <= plot_d;
            done     <= done_d;
            err      <= err_d;
        end
    end

    // Pixel data registers; hold their value on non-plot cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x      <= '0;
            y      <= '0;
            colour <= '0;
        end else begin
            if (load_pix) begin
                x <= X_W'(x_sum);
                y <= Y_W'(y_sum);
            end
            if (load_colour) colour <= colour_in;
        end
    end

endmodule

// File: tb/tb_grid_cell_painter.sv
// Self-checking bench for grid_cell_painter with default geometry.
module tb_grid_cell_painter;

    localparam int NC = 3;
    localparam int NR = 3;
    localparam int CW = 80;
    localparam int CH = 50;
    localparam int OX = 152;
    localparam int OY = 226;
    localparam int PX = 130;
    localparam int PY = 100;

    typedef struct {
        logic [9:0] x;
        logic [8:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        bit         clr;
        int         idx;
        logic [2:0] col;
        bit         exp_err;
        int         exp_plots;
        int         exp_gaps;
        int         fx, fy, lx, ly;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req = 1'b0;
    logic       clear_all = 1'b0;
    logic [7:0] cell_idx = '0;
    logic [2:0] colour_in = '0;
    logic       ready;
    logic [9:0] x;
    logic [8:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       done;
    logic       err;

    grid_cell_painter dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .clear_all (clear_all),
        .cell_idx  (cell_idx),
        .colour_in (colour_in),
        .ready     (ready),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    pix_t exp_q[$];
    int   plot_cnt, done_cnt, err_cnt, rdy_low;
    int   first_x, first_y, last_x, last_y;
    int   first_cyc, done_cyc, err_cyc, acc_cyc;
    bit   seen_first;
    vec_t vecs[6];

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (plot) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_plot: got (%0d,%0d) required no plot", x, y);
            end else begin
                pix_t e;
                e = exp_q.pop_front();
                if (x !== e.x || y !== e.y || colour !== e.c) begin
                    n_bad++;
                    $display("FAIL pixel: got (%0d,%0d,c%0d) required (%0d,%0d,c%0d)",
                             x, y, colour, e.x, e.y, e.c);
                end
            end
            if (!seen_first) begin
                seen_first = 1'b1;
                first_x    = int'(x);
                first_y    = int'(y);
                first_cyc  = cyc;
            end
            last_x = int'(x);
            last_y = int'(y);
            plot_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (!ready) rdy_low++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        seen_first = 1'b0;
        plot_cnt   = 0;
        done_cnt   = 0;
        err_cnt    = 0;
        rdy_low    = 0;
        first_x    = -1;
        first_y    = -1;
        last_x     = -1;
        last_y     = -1;
        first_cyc  = -1;
        done_cyc   = -1;
        err_cyc    = -1;
    endtask

    task automatic push_cell(input int idx, input logic [2:0] c);
        pix_t p;
        int r = idx / NC;
        int k = idx % NC;
        for (int py = 0; py < CH; py++) begin
            for (int px = 0; px < CW; px++) begin
                p.x = 10'(OX + k * PX + px);
                p.y = 9'(OY + r * PY + py);
                p.c = c;
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic do_req(input bit clr, input int idx, input logic [2:0] c);
        int k = 0;
        while (ready !== 1'b1 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (ready !== 1'b1) chk("ready_before_req", 0, 1);
        clear_all = clr;
        cell_idx  = 8'(idx);
        colour_in = c;
        req       = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        req     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("done_seen", done_cnt, 1);
    endtask

    // Watchdog.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{0, 0, 3'b010, 0, 4000, 0, 152, 226, 231, 275};
        vecs[1] = '{0, 8, 3'b010, 0, 4000, 0, 412, 426, 491, 475};
        vecs[2] = '{0, 9, 3'b110, 1, 0,    0, -1,  -1,  -1,  -1};
        vecs[3] = '{0, 4, 3'b101, 0, 4000, 0, 282, 326, 361, 375};
        vecs[4] = '{1, 7, 3'b000, 0, 36000, 8, 152, 226, 491, 475};
        vecs[5] = '{0, 3, 3'b111, 0, 4000, 0, 152, 326, 231, 375};

        // Reset state.
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", int'(ready), 1);
        chk("rst_plot", int'(plot), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_colour", int'(colour), 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Table-driven requests.
        for (int i = 0; i < 6; i++) begin
            clear_stats();
            if (vecs[i].clr) begin
                for (int c = 0; c < NR * NC; c++) push_cell(c, vecs[i].col);
            end else if (!vecs[i].exp_err) begin
                push_cell(vecs[i].idx, vecs[i].col);
            end
            do_req(vecs[i].clr, vecs[i].idx, vecs[i].col);
            if (vecs[i].exp_err) begin
                repeat (6) @(posedge clk);
                #1;
                chk($sformatf("v%0d_err_cnt", i), err_cnt, 1);
                chk($sformatf("v%0d_err_lat", i), err_cyc - acc_cyc, 0);
                chk($sformatf("v%0d_plots", i), plot_cnt, 0);
                chk($sformatf("v%0d_ready_low", i), rdy_low, 0);
                chk($sformatf("v%0d_done", i), done_cnt, 0);
            end else begin
                wait_done(vecs[i].exp_plots + 200);
                #1;
                chk($sformatf("v%0d_ready_after", i), int'(ready), 1);
                chk($sformatf("v%0d_plots", i), plot_cnt, vecs[i].exp_plots);
                chk($sformatf("v%0d_first_x", i), first_x, vecs[i].fx);
                chk($sformatf("v%0d_first_y", i), first_y, vecs[i].fy);
                chk($sformatf("v%0d_last_x", i), last_x, vecs[i].lx);
                chk($sformatf("v%0d_last_y", i), last_y, vecs[i].ly);
                chk($sformatf("v%0d_first_lat", i), first_cyc - acc_cyc, 0);
                chk($sformatf("v%0d_done_lat", i), done_cyc - acc_cyc,
                    vecs[i].exp_plots + vecs[i].exp_gaps);
                chk($sformatf("v%0d_gaps", i), done_cyc - first_cyc - plot_cnt, vecs[i].exp_gaps);
                chk($sformatf("v%0d_err", i), err_cnt, 0);
                chk($sformatf("v%0d_q_left", i), exp_q.size(), 0);
            end
            repeat (2) @(posedge clk);
            #1;
        end

        // Request while busy is ignored.
        clear_stats();
        push_cell(2, 3'b110);
        do_req(0, 2, 3'b110);
        repeat (100) @(posedge clk);
        #1;
        clear_all = 1'b0;
        cell_idx  = 8'd5;
        req       = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        wait_done(4200);
        repeat (20) @(posedge clk);
        #1;
        chk("busy_plots", plot_cnt, 4000);
        chk("busy_done", done_cnt, 1);
        chk("busy_err", err_cnt, 0);
        chk("busy_q_left", exp_q.size(), 0);

        // Asynchronous reset mid-draw, then restart on the same cell.
        clear_stats();
        push_cell(2, 3'b011);
        do_req(0, 2, 3'b011);
        for (int k = 0; k < 5000 && plot_cnt < 1500; k++) @(posedge clk);
        chk("rst_mid_reached", plot_cnt, 1500);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_plot", int'(plot), 0);
        chk("arst_x", int'(x), 0);
        chk("arst_y", int'(y), 0);
        chk("arst_colour", int'(colour), 0);
        chk("arst_ready", int'(ready), 1);
        chk("arst_done", int'(done), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("arst_no_done", done_cnt, 0);
        chk("arst_no_more_plots", plot_cnt, 1500);

        clear_stats();
        push_cell(2, 3'b100);
        do_req(0, 2, 3'b100);
        wait_done(4200);
        #1;
        chk("restart_first_x", first_x, 412);
        chk("restart_first_y", first_y, 226);
        chk("restart_first_lat", first_cyc - acc_cyc, 0);
        chk("restart_plots", plot_cnt, 4000);
        chk("restart_q_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
